// File: rtl/i_cache_dm.sv
// Direct-mapped instruction cache: one line per fetch, single-beat refill over req/ack.
// Hits return a line one cycle after the request; misses stall fetch until the refill is acknowledged.
module i_cache_dm #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        Pc_in,
  input  logic                     Rd_en,
  input  logic                     Flush,
  output logic [32*LINE_WORDS-1:0] Dout,
  output logic                     Dout_valid,
  output logic                     Stall,
  output logic                     Mem_req,
  output logic [ADDR_W-1:0]        Mem_addr,
  input  logic                     Mem_ack,
  input  logic [32*LINE_WORDS-1:0] Mem_data
);

  localparam int unsigned LW    = 32 * LINE_WORDS;
  localparam int unsigned OFF   = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDX   = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - OFF - IDX;

  typedef enum logic {
    S_IDLE,
    S_REFILL
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [IDX-1:0]       idx_q, idx_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 flush_seen_q, flush_seen_d;
  logic [LW-1:0]        dout_d;
  logic                 dout_valid_d;
  logic                 stall_d;
  logic                 mem_req_d;
  logic [ADDR_W-1:0]    mem_addr_d;

  logic [LW-1:0]        data_mem [NUM_LINES];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];

  logic [IDX-1:0]       pc_idx;
  logic [TAG_W-1:0]     pc_tag;
  logic                 hit;
  logic                 wr_en;
  logic                 unused_pc_bits;

  // Address decomposition; the byte offset within a line is not needed for a whole-line fetch.
  assign pc_idx         = Pc_in[OFF +: IDX];
  assign pc_tag         = Pc_in[OFF+IDX +: TAG_W];
  assign unused_pc_bits = ^Pc_in[OFF-1:0];
  assign hit            = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    flush_seen_d = flush_seen_q;
    dout_d       = Dout;
    dout_valid_d = 1'b0;
    stall_d      = Stall;
    mem_req_d    = Mem_req;
    mem_addr_d   = Mem_addr;
    wr_en        = 1'b0;

    // Lookups in the flush cycle still see the old valid bits; only the edge clears them.
    if (Flush) begin
      valid_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (Rd_en) begin
          if (hit) begin
            dout_d       = data_mem[pc_idx];
            dout_valid_d = 1'b1;
          end else begin
            idx_d        = pc_idx;
            tag_d        = pc_tag;
            flush_seen_d = Flush;
            mem_req_d    = 1'b1;
            stall_d      = 1'b1;
            mem_addr_d   = {pc_tag, pc_idx, {OFF{1'b0}}};
            state_d      = S_REFILL;
          end
        end
      end

      S_REFILL: begin
        if (Flush) begin
          flush_seen_d = 1'b1;
        end
        if (Mem_ack) begin
          // A flush anywhere in the refill leaves the new line invalid but still returns it.
          wr_en        = 1'b1;
          if (!(flush_seen_q || Flush)) begin
            valid_d[idx_q] = 1'b1;
          end
          dout_d       = Mem_data;
          dout_valid_d = 1'b1;
          mem_req_d    = 1'b0;
          stall_d      = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        stall_d   = 1'b0;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      idx_q        <= '0;
      tag_q        <= '0;
      flush_seen_q <= 1'b0;
      Dout         <= '0;
      Dout_valid   <= 1'b0;
      Stall        <= 1'b0;
      Mem_req      <= 1'b0;
      Mem_addr     <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      idx_q        <= idx_d;
      tag_q        <= tag_d;
      flush_seen_q <= flush_seen_d;
      Dout         <= dout_d;
      Dout_valid   <= dout_valid_d;
      Stall        <= stall_d;
      Mem_req      <= mem_req_d;
      Mem_addr     <= mem_addr_d;
    end
  end

  // Data and tag storage carry no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[idx_q] <= Mem_data;
      tag_mem[idx_q]  <= tag_q;
    end
  end

endmodule

// File: tb/tb_i_cache_dm.sv
// Self-checking bench for i_cache_dm: directed scenarios plus random fetches against a line-level model.
module tb_i_cache_dm;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned NUM_LINES  = 64;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LW         = 32 * LINE_WORDS;
  localparam int unsigned LINE_BYTES = 4 * LINE_WORDS;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] Pc_in;
  logic              Rd_en;
  logic              Flush;
  logic [LW-1:0]     Dout;
  logic              Dout_valid;
  logic              Stall;
  logic              Mem_req;
  logic [ADDR_W-1:0] Mem_addr;
  logic              Mem_ack;
  logic [LW-1:0]     Mem_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what each line holds, from the cache-level rules only.
  bit          vld_m [NUM_LINES];
  logic [31:0] tag_m [NUM_LINES];
  logic [LW-1:0] dat_m [NUM_LINES];

  i_cache_dm #(
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Pc_in     (Pc_in),
    .Rd_en     (Rd_en),
    .Flush     (Flush),
    .Dout      (Dout),
    .Dout_valid(Dout_valid),
    .Stall     (Stall),
    .Mem_req   (Mem_req),
    .Mem_addr  (Mem_addr),
    .Mem_ack   (Mem_ack),
    .Mem_data  (Mem_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  function automatic int unsigned m_idx(input logic [31:0] a);
    return (a / LINE_BYTES) % NUM_LINES;
  endfunction

  function automatic logic [31:0] m_tag(input logic [31:0] a);
    return a / (LINE_BYTES * NUM_LINES);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return vld_m[m_idx(a)] && (tag_m[m_idx(a)] == m_tag(a));
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NUM_LINES; i++) vld_m[i] = 1'b0;
  endfunction

  function automatic void m_fill(input logic [31:0] a, input logic [LW-1:0] d, input bit keep);
    dat_m[m_idx(a)] = d;
    tag_m[m_idx(a)] = m_tag(a);
    vld_m[m_idx(a)] = keep;
  endfunction

  // Fetch driver: issues one request, serves any refill after 'wt' idle cycles, reports what it saw.
  task automatic fetch(input logic [31:0] a, input int wt, input bit fl,
                       output logic miss, output logic [31:0] maddr, output int stalls,
                       output logic held, output logic dv, output logic [LW-1:0] dout,
                       output logic [LW-1:0] fill);
    for (int i = 0; i < LINE_WORDS; i++) fill[32*i +: 32] = $urandom();
    Pc_in = a;
    Rd_en = 1'b1;
    @(posedge clk); #1;
    miss   = Stall;
    maddr  = Mem_addr;
    stalls = 0;
    held   = 1'b1;
    if (Stall) begin
      stalls = 1;
      if (!Mem_req) held = 1'b0;
      for (int w = 0; w < wt; w++) begin
        if (fl && w == 0) Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        if (Stall) stalls++;
        if (!Mem_req || Mem_addr !== maddr) held = 1'b0;
      end
      Mem_ack  = 1'b1;
      Mem_data = fill;
      if (fl && wt == 0) Flush = 1'b1;
      @(posedge clk); #1;
      Mem_ack = 1'b0;
      Flush   = 1'b0;
      if (Stall) stalls++;
    end
    dv    = Dout_valid;
    dout  = Dout;
    Rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    Pc_in    = '0;
    Rd_en    = 1'b0;
    Flush    = 1'b0;
    Mem_ack  = 1'b0;
    Mem_data = '0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (Dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dout_valid: got %b want 0", Dout_valid); end
    n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", Stall); end
    n_vec++; if (Mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", Mem_req); end
    n_vec++; if (Mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", Mem_addr); end
    n_vec++; if (Dout !== '0) begin n_err++; $display("FAIL reset_dout: got %h want 0", Dout); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_miss_refill();
    logic miss, held, dv; logic [31:0] maddr; int st; logic [LW-1:0] dout, fill;
    fetch(32'h40, 3, 1'b0, miss, maddr, st, held, dv, dout, fill);
    n_vec++; if (miss !== 1'b1) begin n_err++; $display("FAIL first_miss: got %b want 1", miss); end
    n_vec++; if (maddr !== 32'h40) begin n_err++; $display("FAIL first_mem_addr: got %h want 40", maddr); end
    n_vec++; if (st != 4) begin n_err++; $display("FAIL first_stall_cycles: got %0d want 4", st); end
    n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL first_req_held: got %b want 1", held); end
    n_vec++; if (dv !== 1'b1 || dout !== fill) begin n_err++; $display("FAIL first_refill_data: got v=%b %h want v=1 %h", dv, dout, fill); end
    n_vec++; if (Mem_req !== 1'b0) begin n_err++; $display("FAIL first_req_drop: got %b want 0", Mem_req); end
    m_fill(32'h40, fill, 1'b1);
    @(posedge clk); #1;
    n_vec++; if (Dout_valid !== 1'b0) begin n_err++; $display("FAIL first_single_pulse: got %b want 0", Dout_valid); end
    n_vec++; if (Dout !== fill) begin n_err++; $display("FAIL first_dout_hold: got %h want %h", Dout, fill); end
  endtask

  task automatic test_hit();
    logic miss, held, dv; logic [31:0] maddr; int st; logic [LW-1:0] dout, fill;
    fetch(32'h44, 0, 1'b0, miss, maddr, st, held, dv, dout, fill);
    n_vec++; if (miss !== 1'b0) begin n_err++; $display("FAIL hit_44_miss: got %b want 0", miss); end
    n_vec++; if (Mem_req !== 1'b0) begin n_err++; $display("FAIL hit_44_req: got %b want 0", Mem_req); end
    n_vec++; if (dv !== 1'b1 || dout !== dat_m[4]) begin n_err++; $display("FAIL hit_44_data: got v=%b %h want v=1 %h", dv, dout, dat_m[4]); end
  endtask

  task automatic test_conflict();
    logic [31:0] seq [3];
    logic        exp_miss [3];
    logic miss, held, dv; logic [31:0] maddr; int st; logic [LW-1:0] dout, fill, exp_d;
    seq      = '{32'h40, 32'h440, 32'h40};
    exp_miss = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      exp_d = exp_miss[i] ? '0 : dat_m[m_idx(seq[i])];
      fetch(seq[i], 1, 1'b0, miss, maddr, st, held, dv, dout, fill);
      if (exp_miss[i]) exp_d = fill;
      n_vec++; if (miss !== exp_miss[i]) begin n_err++; $display("FAIL conflict_miss[%0d]: got %b want %b", i, miss, exp_miss[i]); end
      n_vec++; if (dv !== 1'b1 || dout !== exp_d) begin n_err++; $display("FAIL conflict_data[%0d]: got v=%b %h want v=1 %h", i, dv, dout, exp_d); end
      if (exp_miss[i]) begin
        n_vec++; if (maddr !== seq[i]) begin n_err++; $display("FAIL conflict_addr[%0d]: got %h want %h", i, maddr, seq[i]); end
        m_fill(seq[i], fill, 1'b1);
      end
    end
  endtask

  task automatic test_flush();
    logic miss, held, dv; logic [31:0] maddr; int st; logic [LW-1:0] dout, fill, old;
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    m_clear();
    fetch(32'h40, 0, 1'b0, miss, maddr, st, held, dv, dout, fill);
    n_vec++; if (miss !== 1'b1 || maddr !== 32'h40) begin n_err++; $display("FAIL flush_then_miss: got miss=%b addr=%h want miss=1 addr=40", miss, maddr); end
    m_fill(32'h40, fill, 1'b1);
    old   = fill;
    Pc_in = 32'h48;
    Rd_en = 1'b1;
    Flush = 1'b1;
    @(posedge clk); #1;
    Rd_en = 1'b0;
    Flush = 1'b0;
    m_clear();
    n_vec++; if (Dout_valid !== 1'b1 || Dout !== old || Stall !== 1'b0) begin n_err++; $display("FAIL flush_same_cycle_hit: got v=%b s=%b %h want v=1 s=0 %h", Dout_valid, Stall, Dout, old); end
    fetch(32'h40, 0, 1'b0, miss, maddr, st, held, dv, dout, fill);
    n_vec++; if (miss !== 1'b1) begin n_err++; $display("FAIL flush_next_lookup_miss: got %b want 1", miss); end
    m_fill(32'h40, fill, 1'b1);
  endtask

  task automatic test_flush_in_refill();
    logic miss, held, dv; logic [31:0] maddr; int st; logic [LW-1:0] dout, fill;
    fetch(32'hC40, 2, 1'b1, miss, maddr, st, held, dv, dout, fill);
    n_vec++; if (miss !== 1'b1 || dv !== 1'b1 || dout !== fill) begin n_err++; $display("FAIL flush_refill_return: got miss=%b v=%b %h want miss=1 v=1 %h", miss, dv, dout, fill); end
    m_clear();
    m_fill(32'hC40, fill, 1'b0);
    fetch(32'hC40, 0, 1'b0, miss, maddr, st, held, dv, dout, fill);
    n_vec++; if (miss !== 1'b1 || maddr !== 32'hC40) begin n_err++; $display("FAIL flush_refill_line_invalid: got miss=%b addr=%h want miss=1 addr=c40", miss, maddr); end
    m_fill(32'hC40, fill, 1'b1);
    fetch(32'hC44, 0, 1'b0, miss, maddr, st, held, dv, dout, fill);
    n_vec++; if (miss !== 1'b0 || dout !== dat_m[4]) begin n_err++; $display("FAIL flush_refill_rehit: got miss=%b %h want miss=0 %h", miss, dout, dat_m[4]); end
  endtask

  task automatic test_ack_ignored();
    logic miss, held, dv; logic [31:0] maddr; int st; logic [LW-1:0] dout, fill;
    Mem_ack = 1'b1;
    for (int i = 0; i < LINE_WORDS; i++) Mem_data[32*i +: 32] = $urandom();
    repeat (2) @(posedge clk);
    #1;
    Mem_ack = 1'b0;
    n_vec++; if (Dout_valid !== 1'b0 || Stall !== 1'b0 || Mem_req !== 1'b0) begin n_err++; $display("FAIL idle_ack_ignored: got v=%b s=%b r=%b want 0 0 0", Dout_valid, Stall, Mem_req); end
    fetch(32'hC40, 0, 1'b0, miss, maddr, st, held, dv, dout, fill);
    n_vec++; if (miss !== 1'b0 || dout !== dat_m[4]) begin n_err++; $display("FAIL idle_ack_no_write: got miss=%b %h want miss=0 %h", miss, dout, dat_m[4]); end
  endtask

  task automatic test_reset_mid_refill();
    logic miss, held, dv; logic [31:0] maddr; int st; logic [LW-1:0] dout, fill;
    Pc_in = 32'h7000;
    Rd_en = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (Mem_req !== 1'b1) begin n_err++; $display("FAIL midrst_req_up: got %b want 1", Mem_req); end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_vec++; if (Mem_req !== 1'b0 || Stall !== 1'b0) begin n_err++; $display("FAIL midrst_async_drop: got r=%b s=%b want 0 0", Mem_req, Stall); end
    Rd_en = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_clear();
    Mem_ack = 1'b1;
    for (int i = 0; i < LINE_WORDS; i++) Mem_data[32*i +: 32] = $urandom();
    @(posedge clk); #1;
    Mem_ack = 1'b0;
    n_vec++; if (Dout_valid !== 1'b0 || Dout !== '0) begin n_err++; $display("FAIL midrst_late_ack: got v=%b %h want v=0 0", Dout_valid, Dout); end
    fetch(32'h7000, 0, 1'b0, miss, maddr, st, held, dv, dout, fill);
    n_vec++; if (miss !== 1'b1) begin n_err++; $display("FAIL midrst_line_miss: got %b want 1", miss); end
    m_fill(32'h7000, fill, 1'b1);
    fetch(32'hC40, 0, 1'b0, miss, maddr, st, held, dv, dout, fill);
    n_vec++; if (miss !== 1'b1) begin n_err++; $display("FAIL midrst_old_line_miss: got %b want 1", miss); end
    m_fill(32'hC40, fill, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic miss, held, dv; logic [31:0] maddr; int st; logic [LW-1:0] dout, fill;
    for (int i = 0; i < 4; i++) begin
      if (!m_hit(32'(i * 16))) begin
        fetch(32'(i * 16), $urandom_range(0, 2), 1'b0, miss, maddr, st, held, dv, dout, fill);
        m_fill(32'(i * 16), fill, 1'b1);
      end
    end
    Rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Pc_in = 32'(i * 16);
      @(posedge clk); #1;
      n_vec++; if (Dout_valid !== 1'b1 || Dout !== dat_m[i]) begin n_err++; $display("FAIL stream[%0d]: got v=%b %h want v=1 %h", i, Dout_valid, Dout, dat_m[i]); end
    end
    Rd_en = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (Dout_valid !== 1'b0) begin n_err++; $display("FAIL stream_end: got %b want 0", Dout_valid); end
  endtask

  task automatic test_random();
    logic miss, held, dv; logic [31:0] maddr, a; int st, wt; bit fl;
    logic [LW-1:0] dout, fill, exp_d; bit exp_miss;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        m_clear();
      end
      a  = 32'($urandom_range(0, 2) * 1024 + $urandom_range(8, 11) * 16 + $urandom_range(0, 3) * 4);
      wt = int'($urandom_range(0, 3));
      fl = ($urandom_range(0, 7) == 0);
      exp_miss = !m_hit(a);
      exp_d    = dat_m[m_idx(a)];
      fetch(a, wt, fl, miss, maddr, st, held, dv, dout, fill);
      if (exp_miss) exp_d = fill;
      n_vec++; if (miss !== exp_miss) begin n_err++; $display("FAIL rand_miss[%0d] a=%h: got %b want %b", n, a, miss, exp_miss); end
      n_vec++; if (dv !== 1'b1 || dout !== exp_d) begin n_err++; $display("FAIL rand_data[%0d] a=%h: got v=%b %h want v=1 %h", n, a, dv, dout, exp_d); end
      if (exp_miss) begin
        n_vec++; if (maddr !== (a - a % LINE_BYTES) || held !== 1'b1) begin n_err++; $display("FAIL rand_addr[%0d]: got %h held=%b want %h held=1", n, maddr, held, a - a % LINE_BYTES); end
        n_vec++; if (st != wt + 1) begin n_err++; $display("FAIL rand_stall[%0d]: got %0d want %0d", n, st, wt + 1); end
        if (fl) m_clear();
        m_fill(a, fill, !fl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_hit();
    test_conflict();
    test_flush();
    test_flush_in_refill();
    test_ack_ignored();
    test_reset_mid_refill();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
